// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared state encoding and boot constants for the imem loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_HDR  = ST_HDR,
        S_DATA = ST_DATA,
        S_CSUM = ST_CSUM,
        S_DONE = ST_DONE,
        S_ERR  = ST_ERR
    } loader_state_t;

    localparam logic [31:0] BOOT_BASE = 32'hBFC00000;
    localparam int          HDR_BYTES = 4;

    // Stream is consumed only while a frame is in flight.
    function automatic logic is_busy(input loader_state_t s);
        return (s == S_HDR) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// ============================================================================
// Module      : imem_loader_if
// Description : Boot stream handshake, memory write port and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_loader_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 8
);
    logic                     start;
    logic                     in_valid;
    logic [DATA_WIDTH-1:0]    in_data;
    logic                     in_ready;
    logic                     we;
    logic [ADDRESS_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0]    wd;
    logic                     busy;
    logic                     done;
    logic                     err;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, we, wa, wd, busy, done, err
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, we, wa, wd, busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Loads a length-prefixed, XOR-checked byte frame into the
//               instruction memory starting at the boot base address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDRESS_WIDTH = 32,
    parameter int          DATA_WIDTH    = 8,
    parameter logic [31:0] BASE_ADDR     = BOOT_BASE,
    parameter int          MEM_BYTES     = 4096
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    imem_loader_if.slave   bus
);

    localparam logic [31:0] c_mem_bytes = 32'(MEM_BYTES);
    localparam logic [31:0] c_hdr_last  = 32'(HDR_BYTES - 1);

    loader_state_t            r_state;
    logic [31:0]              r_len;
    logic [31:0]              r_cnt;
    logic [DATA_WIDTH-1:0]    r_xor;
    logic                     r_we;
    logic [ADDRESS_WIDTH-1:0] r_wa;
    logic [DATA_WIDTH-1:0]    r_wd;
    logic                     r_done;
    logic                     r_err;

    logic                     w_ready;
    logic                     w_accept;
    logic [31:0]              w_len_next;
    logic [ADDRESS_WIDTH-1:0] w_wa;

    assign w_ready    = is_busy(r_state);
    assign w_accept   = bus.in_valid & w_ready;
    assign w_len_next = {r_len[31-DATA_WIDTH:0], bus.in_data};
    // Address arithmetic wraps at the write-port width.
    assign w_wa       = ADDRESS_WIDTH'(BASE_ADDR) + ADDRESS_WIDTH'(r_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_xor   <= '0;
            r_we    <= 1'b0;
            r_wa    <= '0;
            r_wd    <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_len <= '0;
                    r_cnt <= '0;
                    r_xor <= '0;
                    if (bus.start) begin
                        r_state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_accept) begin
                        r_len <= w_len_next;
                        if (r_cnt == c_hdr_last) begin
                            r_cnt <= '0;
                            if (w_len_next == 32'd0) begin
                                r_state <= S_CSUM;
                            end else if ((w_len_next > c_mem_bytes) || (w_len_next[1:0] != 2'b00)) begin
                                r_state <= S_ERR;
                                r_err   <= 1'b1;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_we  <= 1'b1;
                        r_wa  <= w_wa;
                        r_wd  <= bus.in_data;
                        r_cnt <= r_cnt + 32'd1;
                        r_xor <= r_xor ^ bus.in_data;
                        if (r_cnt == r_len - 32'd1) begin
                            r_state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_accept) begin
                        if (bus.in_data == r_xor) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (bus.start) begin
                        r_state <= S_HDR;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_len   <= '0;
                        r_cnt   <= '0;
                        r_xor   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.busy     = w_ready;
    assign bus.we       = r_we;
    assign bus.wa       = r_wa;
    assign bus.wd       = r_wd;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for the boot image loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    logic clk;
    logic rst_n;

    imem_loader_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(8)) bus ();

    imem_loader #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (8),
        .BASE_ADDR    (32'hBFC00000),
        .MEM_BYTES    (4096)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr  = 0;
    logic [31:0] wr_a [64];
    logic [7:0]  wr_d [64];
    logic [7:0]  mem  [logic [31:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Capture every write pulse the memory would see.
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            if (n_wr < 64) begin
                wr_a[n_wr] = bus.wa;
                wr_d[n_wr] = bus.wd;
            end
            mem[bus.wa] = bus.wd;
            n_wr++;
        end
    end

    function automatic logic [31:0] fetch32(input logic [31:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem.exists(a)         ? mem[a]         : 8'h00;
        b1 = mem.exists(a + 32'd1) ? mem[a + 32'd1] : 8'h00;
        b2 = mem.exists(a + 32'd2) ? mem[a + 32'd2] : 8'h00;
        b3 = mem.exists(a + 32'd3) ? mem[a + 32'd3] : 8'h00;
        return {b0, b1, b2, b3};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_wait", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send4(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    int base;

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_we",       {63'd0, bus.we},       64'd0);
        chk("rst_wa",       {32'd0, bus.wa},       64'd0);
        chk("rst_wd",       {56'd0, bus.wd},       64'd0);
        chk("rst_busy",     {63'd0, bus.busy},     64'd0);
        chk("rst_done",     {63'd0, bus.done},     64'd0);
        chk("rst_err",      {63'd0, bus.err},      64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // start and in_valid together in IDLE: byte must not be taken
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        chk("idle_ready", {63'd0, bus.in_ready}, 64'd0);
        pulse_start();
        bus.in_valid = 1'b0;
        chk("hdr_busy", {63'd0, bus.busy}, 64'd1);

        // Nominal load
        base = n_wr;
        send4(32'h00000004);
        send4(32'hDEADBEEF);
        send_byte(8'h22);
        chk("nom_done", {63'd0, bus.done}, 64'd1);
        chk("nom_err",  {63'd0, bus.err},  64'd0);
        chk("nom_busy", {63'd0, bus.busy}, 64'd0);
        chk("nom_nwr",  64'(n_wr - base),  64'd4);
        chk("nom_wa0",  {32'd0, wr_a[base]},     64'hBFC00000);
        chk("nom_wa3",  {32'd0, wr_a[base + 3]}, 64'hBFC00003);
        chk("nom_wd1",  {56'd0, wr_d[base + 1]}, 64'hAD);
        chk("nom_fetch", {32'd0, fetch32(32'hBFC00000)}, 64'hDEADBEEF);

        // Bad checksum
        pulse_start();
        chk("bad_done_clr", {63'd0, bus.done}, 64'd0);
        base = n_wr;
        send4(32'h00000004);
        send4(32'hDEADBEEF);
        send_byte(8'h23);
        chk("bad_err",  {63'd0, bus.err},  64'd1);
        chk("bad_done", {63'd0, bus.done}, 64'd0);
        chk("bad_nwr",  64'(n_wr - base),  64'd4);

        // Over-capacity header
        pulse_start();
        chk("cap_err_clr", {63'd0, bus.err}, 64'd0);
        base = n_wr;
        send4(32'h00001004);
        chk("cap_err",   {63'd0, bus.err},      64'd1);
        chk("cap_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("cap_nwr",   64'(n_wr - base),      64'd0);

        // Misaligned length
        pulse_start();
        base = n_wr;
        send4(32'h00000006);
        chk("mis_err",   {63'd0, bus.err},      64'd1);
        chk("mis_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("mis_nwr",   64'(n_wr - base),      64'd0);

        // Gapped 8-byte payload, in_valid pattern 1,0,0,1
        pulse_start();
        base = n_wr;
        send4(32'h00000008);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(8'h11 * (i + 1)));
            if (i % 2 == 0) begin
                @(negedge clk);
                chk("gap_we", {63'd0, bus.we}, 64'd0);
                @(negedge clk);
            end
        end
        send_byte(8'h88);
        chk("gap_done", {63'd0, bus.done}, 64'd1);
        chk("gap_nwr",  64'(n_wr - base),  64'd8);
        for (int i = 0; i < 8; i++) begin
            chk("gap_wa", {32'd0, wr_a[base + i]}, 64'(32'hBFC00000 + 32'(i)));
            chk("gap_wd", {56'd0, wr_d[base + i]}, 64'(8'h11 * (i + 1)));
        end

        // Empty frame, then restart
        pulse_start();
        base = n_wr;
        send4(32'h00000000);
        send_byte(8'h00);
        chk("empty_done", {63'd0, bus.done}, 64'd1);
        chk("empty_nwr",  64'(n_wr - base),  64'd0);
        pulse_start();
        chk("restart_done_clr", {63'd0, bus.done}, 64'd0);
        send4(32'h00000004);
        send4(32'h01020304);
        send_byte(8'h04);
        chk("restart_done",  {63'd0, bus.done}, 64'd1);
        chk("restart_fetch", {32'd0, fetch32(32'hBFC00000)}, 64'h01020304);

        // Reset mid-load, with a byte offered in the reset cycle
        pulse_start();
        base = n_wr;
        send4(32'h00000008);
        send_byte(8'hA1);
        send_byte(8'hB2);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC3;
        rst_n        = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("mrst_we",    {63'd0, bus.we},       64'd0);
        chk("mrst_busy",  {63'd0, bus.busy},     64'd0);
        chk("mrst_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("mrst_wa",    {32'd0, bus.wa},       64'd0);
        chk("mrst_nwr",   64'(n_wr - base),      64'd2);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        send4(32'h00000004);
        send4(32'hCAFEF00D);
        send_byte(8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D);
        chk("post_done",  {63'd0, bus.done}, 64'd1);
        chk("post_err",   {63'd0, bus.err},  64'd0);
        chk("post_fetch", {32'd0, fetch32(32'hBFC00000)}, 64'hCAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
